// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops and an iterative shift-add multiplier.
// Define ALU_DIV_EN to add the restoring unsigned divider (DIV/REM and the div_zero flag).
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 16,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] outBus,
    output logic             Overflow,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned Msb  = WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle,
        StMul
`ifdef ALU_DIV_EN
        ,
        StDiv
`endif
    } stateT;

    stateT              stateQ, stateD;
    logic [CntW-1:0]    cntQ, cntD;
    // {hi, lo}: running product for MUL, {remainder, quotient} for DIV
    logic [2*WIDTH-1:0] prodQ, prodD;
    logic [WIDTH-1:0]   opndQ, opndD;
    logic               highQ, highD;
    logic               validQ, validD;
    logic [WIDTH-1:0]   outQ, outD;
    logic               ovfQ, ovfD;
    logic               dzQ, dzD;

    logic [WIDTH-1:0]   addRes, subRes, res;
    logic               ovf, dz, multi;
    logic [WIDTH:0]     mulSum;
    logic               lastIter;

    assign addRes   = busA + busB;
    assign subRes   = busA - busB;
    assign mulSum   = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + (prodQ[0] ? {1'b0, opndQ} : '0);
    assign lastIter = cntQ == CntW'(WIDTH - 1);

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   divShift, divDiff;
    logic             divGe;
    logic [WIDTH-1:0] remNext;

    assign divShift = prodQ[2*WIDTH-1:WIDTH-1];
    assign divDiff  = divShift - {1'b0, opndQ};
    assign divGe    = divShift >= {1'b0, opndQ};
    assign remNext  = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
`endif

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        prodD  = prodQ;
        opndD  = opndQ;
        highD  = highQ;
        validD = 1'b0;
        outD   = outQ;
        ovfD   = ovfQ;
        dzD    = dzQ;
        res    = '0;
        ovf    = 1'b0;
        dz     = 1'b0;
        multi  = 1'b0;
        case (stateQ)
            StIdle: begin
                if (in_valid) begin
                    case (AluOp)
                        4'b0000: res = busA & busB;
                        4'b0001: res = busA | busB;
                        4'b0010: res = busA ^ busB;
                        4'b0011: res = ~busA;
                        4'b0100: begin
                            res = addRes;
                            ovf = (busA[Msb] == busB[Msb]) && (addRes[Msb] != busA[Msb]);
                        end
                        4'b0101: begin
                            res = subRes;
                            ovf = (busA[Msb] != busB[Msb]) && (subRes[Msb] != busA[Msb]);
                        end
                        4'b0110: res = {{(WIDTH-1){1'b0}}, $signed(busA) < $signed(busB)};
                        4'b1010: res = busA << imm[SH_W-1:0];
                        4'b1011: res = busA >> imm[SH_W-1:0];
                        4'b1101: res = WIDTH'(imm) << (WIDTH - IMM_W);
                        4'b1000, 4'b1001: begin
                            multi  = 1'b1;
                            stateD = StMul;
                            prodD  = {{WIDTH{1'b0}}, busB};
                            opndD  = busA;
                            highD  = AluOp[0];
                        end
`ifdef ALU_DIV_EN
                        4'b1110, 4'b1111: begin
                            if (busB == '0) begin
                                res = AluOp[0] ? busA : '1;
                                dz  = 1'b1;
                            end else begin
                                multi  = 1'b1;
                                stateD = StDiv;
                                prodD  = {{WIDTH{1'b0}}, busA};
                                opndD  = busB;
                                highD  = AluOp[0];
                            end
                        end
`endif
                        default: res = '0;
                    endcase
                    cntD = '0;
                    // Multi-cycle ops leave the result registers untouched until they finish
                    if (!multi) begin
                        validD = 1'b1;
                        outD   = res;
                        ovfD   = ovf;
                        dzD    = dz;
                    end
                end
            end
            StMul: begin
                prodD = {mulSum, prodQ[WIDTH-1:1]};
                cntD  = cntQ + 1'b1;
                if (lastIter) begin
                    stateD = StIdle;
                    validD = 1'b1;
                    outD   = highQ ? prodD[2*WIDTH-1:WIDTH] : prodD[WIDTH-1:0];
                    ovfD   = 1'b0;
                    dzD    = 1'b0;
                end
            end
`ifdef ALU_DIV_EN
            StDiv: begin
                prodD = {remNext, prodQ[WIDTH-2:0], divGe};
                cntD  = cntQ + 1'b1;
                if (lastIter) begin
                    stateD = StIdle;
                    validD = 1'b1;
                    outD   = highQ ? remNext : {prodQ[WIDTH-2:0], divGe};
                    ovfD   = 1'b0;
                    dzD    = 1'b0;
                end
            end
`endif
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            prodQ  <= '0;
            opndQ  <= '0;
            highQ  <= 1'b0;
            validQ <= 1'b0;
            outQ   <= '0;
            ovfQ   <= 1'b0;
            dzQ    <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            prodQ  <= prodD;
            opndQ  <= opndD;
            highQ  <= highD;
            validQ <= validD;
            outQ   <= outD;
            ovfQ   <= ovfD;
            dzQ    <= dzD;
        end
    end

    assign in_ready  = stateQ == StIdle;
    assign out_valid = validQ;
    assign outBus    = outQ;
    assign Overflow  = ovfQ;
    assign div_zero  = dzQ;

endmodule
